// File: rtl/sr_latch_clocked_if.sv
// Bundle of per-lane set/reset requests and registered SR outputs for sr_latch_clocked.
// The master drives requests and error clears; the slave (the latch bank) returns state.
interface sr_latch_clocked_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic             clr_err;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic [WIDTH-1:0] invalid;
  logic             err_sticky;

  modport master (
    output s, r, clr_err,
    input  q, q_bar, invalid, err_sticky
  );

  modport slave (
    input  s, r, clr_err,
    output q, q_bar, invalid, err_sticky
  );
endinterface

// File: rtl/sr_latch_clocked.sv
// Bank of WIDTH clocked SR latches with true/complement outputs, per-lane forbidden-input
// flags and a sticky error summary. FORBID_MODE selects the s=r=1 behaviour.
module sr_latch_clocked #(
  parameter int WIDTH       = 1,
  parameter int FORBID_MODE = 0
) (
  input logic               clk,
  input logic               rst,
  sr_latch_clocked_if.slave bus
);

  // Encoded as {q_bar, q} so both outputs come straight off flops with no decode.
  typedef enum logic [1:0] {
    LANE_NOR = 2'b00,
    LANE_SET = 2'b01,
    LANE_CLR = 2'b10
  } lane_state_e;

  logic [WIDTH-1:0] q_r, q_bar_r, inv_r;
  logic [WIDTH-1:0] q_d, q_bar_d, inv_d;
  logic             err_r, err_d;

  // Holding from the NOR state (or the unreachable 2'b11) settles to the cleared state.
  function automatic lane_state_e hold_state(input lane_state_e cur);
    lane_state_e nxt;
    nxt = (cur == LANE_SET) ? LANE_SET : LANE_CLR;
    return nxt;
  endfunction

  function automatic lane_state_e forbid_state(input lane_state_e cur);
    lane_state_e nxt;
    case (FORBID_MODE)
      1:       nxt = hold_state(cur);
      2:       nxt = LANE_SET;
      3:       nxt = LANE_CLR;
      default: nxt = LANE_NOR;
    endcase
    return nxt;
  endfunction

  function automatic lane_state_e lane_next(input lane_state_e cur,
                                            input logic        set,
                                            input logic        clr);
    lane_state_e nxt;
    case ({set, clr})
      2'b10:   nxt = LANE_SET;
      2'b01:   nxt = LANE_CLR;
      2'b11:   nxt = forbid_state(cur);
      default: nxt = hold_state(cur);
    endcase
    return nxt;
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    q_d     = q_r;
    q_bar_d = q_bar_r;
    inv_d   = bus.s & bus.r;
    err_d   = err_r;
    for (int i = 0; i < WIDTH; i++) begin
      {q_bar_d[i], q_d[i]} = lane_next(lane_state_e'({q_bar_r[i], q_r[i]}),
                                       bus.s[i], bus.r[i]);
    end
    if (bus.clr_err) err_d = 1'b0;
    // A fresh forbidden input outranks a simultaneous clear.
    if (|inv_d)      err_d = 1'b1;
  end

  // NOTE: state updates use non-blocking assignments; reset is synchronous and overrides all inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r     <= '0;
      q_bar_r <= '1;
      inv_r   <= '0;
      err_r   <= 1'b0;
    end else begin
      q_r     <= q_d;
      q_bar_r <= q_bar_d;
      inv_r   <= inv_d;
      err_r   <= err_d;
    end
  end

  assign bus.q          = q_r;
  assign bus.q_bar      = q_bar_r;
  assign bus.invalid    = inv_r;
  assign bus.err_sticky = err_r;

endmodule

// File: tb/tb_sr_latch_clocked.sv
// Randomised and directed bench for sr_latch_clocked: four WIDTH=4 instances (one per
// FORBID_MODE) and one WIDTH=1 mode-0 instance, all checked against a truth-table model.
module tb_sr_latch_clocked;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] s4, r4;
  logic       s1, r1;
  logic       clr_err;

  always #5 clk = ~clk;

  sr_latch_clocked_if #(.WIDTH(4)) bus_m0 ();
  sr_latch_clocked_if #(.WIDTH(4)) bus_m1 ();
  sr_latch_clocked_if #(.WIDTH(4)) bus_m2 ();
  sr_latch_clocked_if #(.WIDTH(4)) bus_m3 ();
  sr_latch_clocked_if #(.WIDTH(1)) bus_w1 ();

  assign bus_m0.s = s4;  assign bus_m0.r = r4;  assign bus_m0.clr_err = clr_err;
  assign bus_m1.s = s4;  assign bus_m1.r = r4;  assign bus_m1.clr_err = clr_err;
  assign bus_m2.s = s4;  assign bus_m2.r = r4;  assign bus_m2.clr_err = clr_err;
  assign bus_m3.s = s4;  assign bus_m3.r = r4;  assign bus_m3.clr_err = clr_err;
  assign bus_w1.s = s1;  assign bus_w1.r = r1;  assign bus_w1.clr_err = clr_err;

  sr_latch_clocked #(.WIDTH(4), .FORBID_MODE(0)) u_m0 (.clk(clk), .rst(rst), .bus(bus_m0));
  sr_latch_clocked #(.WIDTH(4), .FORBID_MODE(1)) u_m1 (.clk(clk), .rst(rst), .bus(bus_m1));
  sr_latch_clocked #(.WIDTH(4), .FORBID_MODE(2)) u_m2 (.clk(clk), .rst(rst), .bus(bus_m2));
  sr_latch_clocked #(.WIDTH(4), .FORBID_MODE(3)) u_m3 (.clk(clk), .rst(rst), .bus(bus_m3));
  sr_latch_clocked #(.WIDTH(1), .FORBID_MODE(0)) u_w1 (.clk(clk), .rst(rst), .bus(bus_w1));

  typedef struct packed {
    logic [3:0] q;
    logic [3:0] qb;
    logic [3:0] inv;
    logic       err;
  } obs_t;

  // Index 0..3 = WIDTH=4 instance with that FORBID_MODE, index 4 = WIDTH=1 mode 0.
  obs_t exp_o [5];
  int   n_err = 0;
  int   n_chk = 0;

  function automatic obs_t observe(input int k);
    obs_t o;
    o = '0;
    case (k)
      0: o = '{q: bus_m0.q, qb: bus_m0.q_bar, inv: bus_m0.invalid, err: bus_m0.err_sticky};
      1: o = '{q: bus_m1.q, qb: bus_m1.q_bar, inv: bus_m1.invalid, err: bus_m1.err_sticky};
      2: o = '{q: bus_m2.q, qb: bus_m2.q_bar, inv: bus_m2.invalid, err: bus_m2.err_sticky};
      3: o = '{q: bus_m3.q, qb: bus_m3.q_bar, inv: bus_m3.invalid, err: bus_m3.err_sticky};
      default: o = '{q: {3'b0, bus_w1.q}, qb: {3'b0, bus_w1.q_bar},
                     inv: {3'b0, bus_w1.invalid}, err: bus_w1.err_sticky};
    endcase
    return o;
  endfunction

  // Reference: applies the SR truth table lane by lane to the inputs present before the edge.
  task automatic model_edge();
    for (int k = 0; k < 5; k++) begin
      int   mode  = (k == 4) ? 0 : k;
      int   lanes = (k == 4) ? 1 : 4;
      logic any_forbid = 1'b0;
      for (int i = 0; i < lanes; i++) begin
        logic si = (k == 4) ? s1 : s4[i];
        logic ri = (k == 4) ? r1 : r4[i];
        if (rst) begin
          exp_o[k].q[i] = 1'b0; exp_o[k].qb[i] = 1'b1; exp_o[k].inv[i] = 1'b0;
        end else begin
          exp_o[k].inv[i] = si && ri;
          if (si && ri) begin
            any_forbid = 1'b1;
            if (mode == 0)      begin exp_o[k].q[i] = 1'b0; exp_o[k].qb[i] = 1'b0; end
            else if (mode == 2) begin exp_o[k].q[i] = 1'b1; exp_o[k].qb[i] = 1'b0; end
            else if (mode == 3) begin exp_o[k].q[i] = 1'b0; exp_o[k].qb[i] = 1'b1; end
          end else if (si) begin
            exp_o[k].q[i] = 1'b1; exp_o[k].qb[i] = 1'b0;
          end else if (ri) begin
            exp_o[k].q[i] = 1'b0; exp_o[k].qb[i] = 1'b1;
          end else if (!exp_o[k].q[i] && !exp_o[k].qb[i]) begin
            exp_o[k].qb[i] = 1'b1;
          end
        end
      end
      if (rst)             exp_o[k].err = 1'b0;
      else if (any_forbid) exp_o[k].err = 1'b1;
      else if (clr_err)    exp_o[k].err = 1'b0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] s_v, input logic [3:0] r_v, input logic clr_v);
    s4 = s_v; r4 = r_v; s1 = s_v[0]; r1 = r_v[0]; clr_err = clr_v; rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; s4 = 4'hF; r4 = 4'h0; s1 = 1'b1; r1 = 1'b0; clr_err = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      obs_t o = observe(k);
      obs_t want = (k == 4) ? obs_t'{q: 4'h0, qb: 4'h1, inv: 4'h0, err: 1'b0}
                            : obs_t'{q: 4'h0, qb: 4'hF, inv: 4'h0, err: 1'b0};
      n_chk++;
      if (o !== want) begin
        n_err++;
        $display("FAIL reset inst%0d: got %b/%b/%b/%b want %b/%b/%b/%b", k,
                 o.q, o.qb, o.inv, o.err, want.q, want.qb, want.inv, want.err);
      end
    end
  endtask

  task automatic test_set_clear_hold();
    logic [3:0] s_seq [5] = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0] r_seq [5] = '{4'h0, 4'hF, 4'h0, 4'h0, 4'h0};
    for (int t = 0; t < 5; t++) begin
      drive(s_seq[t], r_seq[t], 1'b0);
      tick();
      for (int k = 0; k < 5; k++) begin
        obs_t o = observe(k);
        n_chk++;
        if (o !== exp_o[k]) begin
          n_err++;
          $display("FAIL set_clear_hold step%0d inst%0d: got %b/%b/%b/%b want %b/%b/%b/%b", t, k,
                   o.q, o.qb, o.inv, o.err, exp_o[k].q, exp_o[k].qb, exp_o[k].inv, exp_o[k].err);
        end
      end
    end
    n_chk++;
    if (bus_w1.q !== 1'b0 || bus_w1.q_bar !== 1'b1) begin
      n_err++;
      $display("FAIL hold_after_clear: got q=%b q_bar=%b want q=0 q_bar=1", bus_w1.q, bus_w1.q_bar);
    end
  endtask

  task automatic test_forbid_nor();
    drive(4'hF, 4'hF, 1'b0);
    tick();
    n_chk++;
    if ({bus_w1.q, bus_w1.q_bar, bus_w1.invalid, bus_w1.err_sticky} !== 4'b0011) begin
      n_err++;
      $display("FAIL forbid_nor: got q/qb/inv/err=%b%b%b%b want 0011",
               bus_w1.q, bus_w1.q_bar, bus_w1.invalid, bus_w1.err_sticky);
    end
    drive(4'h0, 4'hF, 1'b0);
    tick();
    n_chk++;
    if ({bus_w1.q, bus_w1.q_bar, bus_w1.invalid, bus_w1.err_sticky} !== 4'b0101) begin
      n_err++;
      $display("FAIL forbid_recover: got q/qb/inv/err=%b%b%b%b want 0101",
               bus_w1.q, bus_w1.q_bar, bus_w1.invalid, bus_w1.err_sticky);
    end
    drive(4'h0, 4'h0, 1'b1);
    tick();
    for (int k = 0; k < 5; k++) begin
      obs_t o = observe(k);
      n_chk++;
      if (o !== exp_o[k] || o.err !== 1'b0) begin
        n_err++;
        $display("FAIL clr_err inst%0d: got %b/%b/%b/%b want %b/%b/%b/%b", k,
                 o.q, o.qb, o.inv, o.err, exp_o[k].q, exp_o[k].qb, exp_o[k].inv, exp_o[k].err);
      end
    end
  endtask

  task automatic test_forbid_modes();
    obs_t want [4];
    want[0] = '{q: 4'h0, qb: 4'h0, inv: 4'hF, err: 1'b1};
    want[1] = '{q: 4'hF, qb: 4'h0, inv: 4'hF, err: 1'b1};
    want[2] = '{q: 4'hF, qb: 4'h0, inv: 4'hF, err: 1'b1};
    want[3] = '{q: 4'h0, qb: 4'hF, inv: 4'hF, err: 1'b1};
    drive(4'hF, 4'h0, 1'b0);
    tick();
    drive(4'hF, 4'hF, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      obs_t o = observe(k);
      n_chk++;
      if (o !== want[k]) begin
        n_err++;
        $display("FAIL forbid_mode%0d: got %b/%b/%b/%b want %b/%b/%b/%b", k,
                 o.q, o.qb, o.inv, o.err, want[k].q, want[k].qb, want[k].inv, want[k].err);
      end
    end
    // Mode 0 lanes leave the all-zero state on the following hold.
    drive(4'h0, 4'h0, 1'b0);
    tick();
    n_chk++;
    if (bus_m0.q !== 4'h0 || bus_m0.q_bar !== 4'hF || bus_m0.invalid !== 4'h0) begin
      n_err++;
      $display("FAIL nor_resolve: got q=%b q_bar=%b inv=%b want 0000/1111/0000",
               bus_m0.q, bus_m0.q_bar, bus_m0.invalid);
    end
  endtask

  task automatic test_mixed_lanes();
    rst = 1'b1;
    tick();
    drive(4'b0101, 4'b0011, 1'b0);
    tick();
    n_chk++;
    if (bus_m0.q !== 4'b0100 || bus_m0.q_bar !== 4'b1010 || bus_m0.invalid !== 4'b0001) begin
      n_err++;
      $display("FAIL mixed_lanes: got q=%b q_bar=%b inv=%b want 0100/1010/0001",
               bus_m0.q, bus_m0.q_bar, bus_m0.invalid);
    end
    for (int k = 1; k < 5; k++) begin
      obs_t o = observe(k);
      n_chk++;
      if (o !== exp_o[k]) begin
        n_err++;
        $display("FAIL mixed_lanes inst%0d: got %b/%b/%b/%b want %b/%b/%b/%b", k,
                 o.q, o.qb, o.inv, o.err, exp_o[k].q, exp_o[k].qb, exp_o[k].inv, exp_o[k].err);
      end
    end
  endtask

  task automatic test_simultaneous();
    drive(4'hF, 4'h0, 1'b0);
    tick();
    rst = 1'b1; clr_err = 1'b0;
    tick();
    n_chk++;
    if (bus_w1.q !== 1'b0 || bus_w1.q_bar !== 1'b1 || bus_m2.q !== 4'h0) begin
      n_err++;
      $display("FAIL reset_overrides_set: got q=%b q_bar=%b m2.q=%b want 0/1/0000",
               bus_w1.q, bus_w1.q_bar, bus_m2.q);
    end
    drive(4'h2, 4'h2, 1'b1);
    tick();
    n_chk++;
    if (bus_m0.err_sticky !== 1'b1 || bus_m3.err_sticky !== 1'b1 || bus_m0.invalid !== 4'h2) begin
      n_err++;
      $display("FAIL set_beats_clear: got err=%b/%b inv=%b want 1/1/0010",
               bus_m0.err_sticky, bus_m3.err_sticky, bus_m0.invalid);
    end
    // Lane 1 alone is forbidden; the WIDTH=1 instance sees none, so its clear succeeds.
    n_chk++;
    if (bus_w1.err_sticky !== exp_o[4].err) begin
      n_err++;
      $display("FAIL w1_clear: got err=%b want %b", bus_w1.err_sticky, exp_o[4].err);
    end
  endtask

  task automatic test_no_comb_path();
    drive(4'h0, 4'h0, 1'b0);
    tick();
    s4 = 4'hA; r4 = 4'h5; s1 = 1'b1; r1 = 1'b1; clr_err = 1'b1; rst = 1'b1;
    #3;
    for (int k = 0; k < 5; k++) begin
      obs_t o = observe(k);
      n_chk++;
      if (o !== exp_o[k]) begin
        n_err++;
        $display("FAIL no_comb_path inst%0d: got %b/%b/%b/%b want %b/%b/%b/%b", k,
                 o.q, o.qb, o.inv, o.err, exp_o[k].q, exp_o[k].qb, exp_o[k].inv, exp_o[k].err);
      end
    end
    drive(4'h0, 4'h0, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      s4      = 4'($urandom);
      r4      = 4'($urandom);
      s1      = 1'($urandom_range(0, 1));
      r1      = 1'($urandom_range(0, 1));
      clr_err = ($urandom_range(0, 7) == 0);
      rst     = ($urandom_range(0, 31) == 0);
      tick();
      for (int k = 0; k < 5; k++) begin
        obs_t o = observe(k);
        n_chk++;
        if (o !== exp_o[k]) begin
          n_err++;
          $display("FAIL random cyc%0d inst%0d: got %b/%b/%b/%b want %b/%b/%b/%b", t, k,
                   o.q, o.qb, o.inv, o.err, exp_o[k].q, exp_o[k].qb, exp_o[k].inv, exp_o[k].err);
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 5; k++) exp_o[k] = '0;
    test_reset();
    test_set_clear_hold();
    test_forbid_nor();
    test_forbid_modes();
    test_mixed_lanes();
    test_simultaneous();
    test_no_comb_path();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sr_latch_clocked.md
Name: sr_latch_clocked

Overview:
Clocked, synchronous equivalent of a NOR-style SR latch, replicated across WIDTH independent bit lanes. Each lane holds one stored bit, driven by set (s) and reset (r) requests sampled on the rising clock edge. Each lane provides true and complement outputs, a per-lane flag for forbidden (S=R=1) inputs, and a sticky error summary. Used wherever set/clear status bits are needed inside the synchronous domain, replacing combinational cross-coupled latches.

Parameters:
WIDTH, 1, number of independent SR lanes (1..64).
FORBID_MODE, 0, action on s=1,r=1: 0 = NOR emulation (q=0, q_bar=0); 1 = hold; 2 = set wins; 3 = reset wins.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
s  input  WIDTH  per-lane set request.
r  input  WIDTH  per-lane reset request.
clr_err  input  1  synchronous clear of err_sticky.
q  output  WIDTH  stored value per lane (registered).
q_bar  output  WIDTH  complement output per lane (registered; not always ~q, see Behaviour).
invalid  output  WIDTH  per lane: high for the cycle after s=r=1 was sampled.
err_sticky  output  1  set when any lane samples s=r=1; held until cleared.

Behaviour:
- One clock domain. All state updates occur on the rising edge of clk. Outputs are registered with 1-cycle latency from the sampled inputs.
- Reset: when rst=1 at an edge, every lane takes q=0, q_bar=1, invalid=0, and err_sticky=0. Reset overrides s, r and clr_err.
- Per-lane truth table at each edge (rst=0):
  - s=0, r=0: hold. q and q_bar keep their values. If the previous state was forbidden (q=0, q_bar=0, mode 0), the lane resolves to q=0, q_bar=1; it never oscillates or goes X.
  - s=1, r=0: q=1, q_bar=0.
  - s=0, r=1: q=0, q_bar=1.
  - s=1, r=1 (forbidden): invalid=1 for that lane. Outputs depend on FORBID_MODE:
    - Mode 0: q=0, q_bar=0.
    - Mode 1: hold.
    - Mode 2: q=1, q_bar=0.
    - Mode 3: q=0, q_bar=1.
- In every case other than forbidden mode 0, q_bar is exactly ~q.
- invalid[i] is registered. It is 1 only in the cycle following a sampled s[i]=r[i]=1 and returns to 0 on any other input.
- err_sticky:
  - Goes to 1 at the edge where any lane samples s=r=1.
  - Cleared to 0 by clr_err=1 at an edge.
  - If clr_err and a new forbidden input occur at the same edge, err_sticky ends at 1 (set wins over clear).
- Lanes are fully independent; no cross-lane interaction except through err_sticky.
- X/undriven s or r before the first reset is not required to produce defined outputs. Outputs must be defined from the first edge with rst=1 onward.
- Input changes between clock edges have no effect; there is no combinational path from input to output.

Test Plan:
1. WIDTH=1, mode 0: hold rst=1 for 2 cycles -> q=0, q_bar=1, invalid=0, err_sticky=0.
2. Apply s=1,r=0 -> next edge q=1, q_bar=0. Then s=0,r=1 -> q=0, q_bar=1. Then s=0,r=0 for 3 cycles -> q stays 0.
3. Forbidden, mode 0: s=1,r=1 -> q=0, q_bar=0, invalid=1, err_sticky=1. Then s=0,r=1 -> q=0, q_bar=1, invalid=0, err_sticky stays 1. Then clr_err=1 -> err_sticky=0.
4. Forbidden in each mode with prior q=1 -> mode 1 gives q=1/q_bar=0; mode 2 gives 1/0; mode 3 gives 0/1. invalid=1 in all modes.
5. WIDTH=4: s=4'b0101, r=4'b0011 -> q=4'b0100 (lane0 forbidden, mode 0), q_bar=4'b1010, invalid=4'b0001.
6. Simultaneous events: with q=1 apply rst=1, s=1, r=0 -> q=0, q_bar=1. Apply clr_err=1 together with s=r=1 -> err_sticky=1.
